imm_gen_pipe: RTL
=================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, immediate width; legal values 32, 64.
REQ-002 Parameter EN_CSR, default 1, enables decode of Zicsr zimm immediates.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous discard of all held entries.
REQ-006 in_valid  input  1  instruction word offered.
REQ-007 in_ready  output  1  stage can accept; registered, not combinational on out_ready.
REQ-008 instr  input  32  raw RV32/RV64 instruction word.
REQ-009 out_valid  output  1  result held on imm/imm_type/illegal.
REQ-010 out_ready  input  1  consumer accepts.
REQ-011 imm  output  XLEN  extended immediate.
REQ-012 imm_type  output  3  imm_type_e format tag.
REQ-013 illegal  output  1  opcode not recognised.

Function
REQ-014 Decode: OP_IMM/LOAD/JALR -> I sign-extended; STORE -> S; BRANCH -> B (bit0=0); LUI/AUIPC -> U, low 12 bits zero, sign-extended to XLEN; JAL -> J (bit0=0).
REQ-015 OP_IMM funct3 001/101 -> IMM_SHAMT, zero-extended shamt: instr[24:20] when XLEN=32, instr[25:20] when XLEN=64; funct7 bits excluded.
REQ-016 SYSTEM, EN_CSR=1, funct3[2]=1 -> IMM_Z, instr[19:15] zero-extended; other SYSTEM -> IMM_NONE, imm 0.
REQ-017 SYSTEM with EN_CSR=0 -> IMM_NONE, imm 0, illegal 0.
REQ-018 Unlisted opcode -> IMM_NONE, imm 0, illegal 1.
REQ-019 Handshake transfer on valid&&ready at rising edge; in_valid and instr must hold stable while in_valid&&!in_ready.
REQ-020 Latency exactly one cycle: word accepted at edge N is on outputs with out_valid=1 after edge N, given empty stage.
REQ-021 Throughput one word per cycle while out_ready=1.
REQ-022 Storage: main output register plus one skid register; two entries max.
REQ-023 Accept while main valid and out_ready=0 -> decoded word into skid; in_ready=0 from next cycle.
REQ-024 Main consumed while skid valid -> skid moves to main same edge; in_ready=1 next cycle.
REQ-025 Main consumed and new accept same edge, skid empty -> new word into main.
REQ-026 Strict FIFO order; no loss, no duplication.
REQ-027 Outputs stable while out_valid&&!out_ready.
REQ-028 flush=1 at edge: main and skid invalid, incoming word dropped, in_ready=1 next cycle; flush overrides simultaneous accept/consume.
REQ-029 out_valid=0 -> imm, imm_type, illegal driven 0.

Reset
REQ-030 rst_n low: out_valid=0, skid invalid, imm=0, imm_type=IMM_NONE, illegal=0, in_ready=1 immediately.
REQ-031 Reset mid-transfer discards both entries; first accept allowed at first edge after rst_n high.

Structure
REQ-032 imm_type_e (IMM_NONE,I,S,B,U,J,SHAMT,Z) and opcode constants in lx32_arch_pkg; get_*_imm functions there generalised to XLEN.
REQ-033 Decode is combinational ahead of registers; no combinational path out_ready -> in_ready.
REQ-034 One sub-module: skid_buffer, parametrised payload width, holds main+skid registers.

Verification
REQ-035 XLEN=32, instr 0xFFF00093 (addi x1,x0,-1) -> next cycle imm 0xFFFFFFFF, IMM_I, illegal 0.
REQ-036 instr 0x40515093 (srai x1,x2,5) -> imm 0x00000005, IMM_SHAMT; XLEN=64 same word -> 0x5.
REQ-037 instr 0xFFDFF06F (jal x0,-4) -> imm 0xFFFFFFFC, IMM_J; EN_CSR=1, 0x300FD073 -> imm 0x1F, IMM_Z.
REQ-038 Stream 4 words, out_ready=0 for 3 cycles -> in_ready low after 2 held, resumes; all 4 out in order.
REQ-039 Skid full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, no dropped word appears.
REQ-040 rst_n low with main+skid full, opcode 0x7F pending -> outputs zero, in_ready=1; 0x7F post-reset -> illegal=1, imm 0.

Source files
------------

// File: rtl/lx32_arch_pkg.sv
`default_nettype none
// ============================================================================
// lx32_arch_pkg : RV32/RV64 opcode constants, immediate format tags and
//                 immediate extraction helpers (sign-extended to MAX_XLEN)
// Revision      : 1.0
// ============================================================================
package lx32_arch_pkg;

    localparam int MAX_XLEN = 64;

    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_S     = 3'd2,
        IMM_B     = 3'd3,
        IMM_U     = 3'd4,
        IMM_J     = 3'd5,
        IMM_SHAMT = 3'd6,
        IMM_Z     = 3'd7
    } imm_type_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Callers narrow the MAX_XLEN result to their own XLEN; narrowing a
    // sign-extended value is itself a correct sign extension.
    function automatic logic [MAX_XLEN-1:0] get_i_imm(input logic [31:0] instr);
        return {{(MAX_XLEN-12){instr[31]}}, instr[31:20]};
    endfunction

    function automatic logic [MAX_XLEN-1:0] get_s_imm(input logic [31:0] instr);
        return {{(MAX_XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    endfunction

    function automatic logic [MAX_XLEN-1:0] get_b_imm(input logic [31:0] instr);
        return {{(MAX_XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic logic [MAX_XLEN-1:0] get_u_imm(input logic [31:0] instr);
        return {{(MAX_XLEN-32){instr[31]}}, instr[31:12], 12'b0};
    endfunction

    function automatic logic [MAX_XLEN-1:0] get_j_imm(input logic [31:0] instr);
        return {{(MAX_XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    function automatic logic [MAX_XLEN-1:0] get_shamt_imm(input logic [31:0] instr,
                                                          input logic        wide);
        return {{(MAX_XLEN-6){1'b0}}, instr[25] & wide, instr[24:20]};
    endfunction

    function automatic logic [MAX_XLEN-1:0] get_z_imm(input logic [31:0] instr);
        return {{(MAX_XLEN-5){1'b0}}, instr[19:15]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/skid_buffer.sv
`default_nettype none
// ============================================================================
// skid_buffer : two-entry valid/ready register slice (main + skid) with
//               registered in_ready and zeroed payload while empty
// Revision    : 1.0
// ============================================================================
module skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             r_main_valid;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;
    logic             w_accept;
    logic             w_consume;

    // Ready depends only on skid occupancy, so out_ready never reaches in_ready.
    assign in_ready  = ~r_skid_valid;
    assign w_accept  = in_valid & ~r_skid_valid;
    assign w_consume = r_main_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_data  <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid || w_consume) begin
            if (r_skid_valid) begin
                r_main_data  <= r_skid_data;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_main_valid <= w_accept;
                if (w_accept) begin
                    r_main_data <= in_data;
                end
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= in_data;
        end
    end

    assign out_valid = r_main_valid;
    assign out_data  = r_main_valid ? r_main_data : '0;

endmodule
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// imm_gen_pipe : RV32/RV64 immediate generator, combinational decode followed
//                by a two-entry skid-buffered output stage
// Revision     : 1.0
// ============================================================================
module imm_gen_pipe
    import lx32_arch_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int EN_CSR = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output imm_type_e       imm_type,
    output logic            illegal
);

    localparam int PAYLOAD_W = XLEN + 4;

    logic [6:0]           w_opcode;
    logic [2:0]           w_funct3;
    logic [XLEN-1:0]      w_imm;
    imm_type_e            w_type;
    logic                 w_illegal;
    logic [PAYLOAD_W-1:0] w_in_data;
    logic [PAYLOAD_W-1:0] w_out_data;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];

    always_comb begin
        w_imm     = '0;
        w_type    = IMM_NONE;
        w_illegal = 1'b0;
        case (w_opcode)
            OPC_OP_IMM: begin
                if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
                    w_imm  = XLEN'(get_shamt_imm(instr, XLEN == 64));
                    w_type = IMM_SHAMT;
                end else begin
                    w_imm  = XLEN'(get_i_imm(instr));
                    w_type = IMM_I;
                end
            end
            OPC_LOAD, OPC_JALR: begin
                w_imm  = XLEN'(get_i_imm(instr));
                w_type = IMM_I;
            end
            OPC_STORE: begin
                w_imm  = XLEN'(get_s_imm(instr));
                w_type = IMM_S;
            end
            OPC_BRANCH: begin
                w_imm  = XLEN'(get_b_imm(instr));
                w_type = IMM_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                w_imm  = XLEN'(get_u_imm(instr));
                w_type = IMM_U;
            end
            OPC_JAL: begin
                w_imm  = XLEN'(get_j_imm(instr));
                w_type = IMM_J;
            end
            OPC_SYSTEM: begin
                // Non-CSR-immediate SYSTEM words are legal but carry no immediate.
                if (EN_CSR != 0 && w_funct3[2]) begin
                    w_imm  = XLEN'(get_z_imm(instr));
                    w_type = IMM_Z;
                end
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    assign w_in_data = {w_illegal, w_type, w_imm};

    skid_buffer #(
        .WIDTH (PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_data)
    );

    assign imm      = w_out_data[XLEN-1:0];
    assign imm_type = imm_type_e'(w_out_data[XLEN+2:XLEN]);
    assign illegal  = w_out_data[XLEN+3];

endmodule
`default_nettype wire
